// File: rtl/nas_vid_gen.sv
// NASCOM-style text video generator: VRAM fetch, glyph lookup, dot serialiser, syncs.
// Optional NAS_VID_INVERSE_EN: vram_data[7] set shows the character in inverse video.
module nas_vid_gen #(
  parameter int CLK_DIV      = 2,
  parameter int H_CHARS      = 64,
  parameter int COLS         = 48,
  parameter int H_SYNC_START = 52,
  parameter int H_SYNC_CHARS = 5,
  parameter int ROWS         = 16,
  parameter int SCAN         = 16,
  parameter int V_LINES      = 312,
  parameter int V_SYNC_START = 280,
  parameter int V_SYNC_LINES = 10,
  parameter int H_STRIDE     = 64,
  parameter int TOP_ROW      = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vdusel_n,
  output logic [9:0]  vram_addr,
  input  logic [7:0]  vram_data,
  output logic [10:0] font_addr,
  input  logic [7:0]  font_data,
  output logic        vid_data,
  output logic        vid_sync,
  output logic        hsync,
  output logic        vsync,
  output logic        active
);

  localparam int DW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int SW   = (H_CHARS > 1) ? $clog2(H_CHARS) : 1;
  localparam int LW   = (V_LINES > 1) ? $clog2(V_LINES) : 1;
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int VACT = ROWS * SCAN;

  if (COLS > H_CHARS) begin : g_bad_cols
    $error("COLS exceeds H_CHARS");
  end
  if (H_SYNC_START + H_SYNC_CHARS > H_CHARS) begin : g_bad_hsync
    $error("hsync extends past H_CHARS");
  end
  if (VACT > V_SYNC_START) begin : g_bad_vact
    $error("ROWS*SCAN exceeds V_SYNC_START");
  end
  if (V_SYNC_START + V_SYNC_LINES > V_LINES) begin : g_bad_vsync
    $error("vsync extends past V_LINES");
  end
  if (SCAN < 1 || SCAN > 16) begin : g_bad_scan
    $error("SCAN must be 1..16");
  end

  logic [DW-1:0] div_cnt;
  logic          pix_en;
  logic [2:0]    dot;
  logic [SW-1:0] slot;
  logic [LW-1:0] line;
  logic [3:0]    scan;
  logic [RW-1:0] mem_row;
  logic          slot_end;
  logic          slot_last;
  logic          line_last;
  logic          h_now;
  logic          v_now;
  logic          a_now;
  logic [2:0]    s1;
  logic [2:0]    s2;
  logic [7:0]    shifter;
  logic [7:0]    glyph;

  assign pix_en    = div_cnt == DW'(CLK_DIV - 1);
  assign slot_end  = pix_en && dot == 3'd7;
  assign slot_last = slot == SW'(H_CHARS - 1);
  assign line_last = line == LW'(V_LINES - 1);

  assign h_now = 32'(slot) >= H_SYNC_START &&
                 32'(slot) < H_SYNC_START + H_SYNC_CHARS;
  assign v_now = 32'(line) >= V_SYNC_START &&
                 32'(line) < V_SYNC_START + V_SYNC_LINES;
  assign a_now = 32'(slot) < COLS && 32'(line) < VACT;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (pix_en) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // scan and mem_row track line incrementally, avoiding a divider
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dot     <= '0;
      slot    <= '0;
      line    <= '0;
      scan    <= '0;
      mem_row <= RW'(TOP_ROW % ROWS);
    end else if (pix_en) begin
      dot <= dot + 1'b1;
      if (dot == 3'd7) begin
        slot <= slot_last ? '0 : slot + 1'b1;
        if (slot_last) begin
          if (line_last) begin
            line    <= '0;
            scan    <= '0;
            mem_row <= RW'(TOP_ROW % ROWS);
          end else begin
            line <= line + 1'b1;
            if (scan == 4'(SCAN - 1)) begin
              scan    <= '0;
              mem_row <= (mem_row == RW'(ROWS - 1)) ? '0 : mem_row + 1'b1;
            end else begin
              scan <= scan + 1'b1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vram_addr <= '0;
    end else begin
      vram_addr <= 10'(mem_row) * 10'(H_STRIDE) + 10'(slot);
    end
  end

`ifdef NAS_VID_INVERSE_EN
  logic inv_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inv_q <= 1'b0;
    end else if (slot_end) begin
      inv_q <= vram_data[7];
    end
  end

  assign glyph = font_data ^ {8{inv_q}};
`else
  logic unused_attr;

  assign unused_attr = vram_data[7];
  assign glyph       = font_data;
`endif

  // slot c: fetch char; c+1: fetch glyph; c+2: shift dots out
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      font_addr <= '0;
      s1        <= '0;
      s2        <= '0;
      shifter   <= '0;
    end else if (slot_end) begin
      font_addr <= {vram_data[6:0], scan};
      s1        <= {h_now, v_now, a_now};
      s2        <= s1;
      shifter   <= glyph;
    end else if (pix_en) begin
      shifter <= {shifter[6:0], 1'b0};
    end
  end

  assign hsync    = s2[2];
  assign vsync    = s2[1];
  assign active   = s2[0];
  assign vid_data = active & shifter[7] & vdusel_n;
  assign vid_sync = ~(hsync | vsync);

endmodule

// File: tb/tb_nas_vid_gen.sv
// Bench for nas_vid_gen: raster reference model, address table, sync timing.
// Build with or without NAS_VID_INVERSE_EN to match the RTL configuration.
module tb_nas_vid_gen;

  localparam int CD    = 2;
  localparam int HC    = 64;
  localparam int COLS  = 48;
  localparam int HSS   = 52;
  localparam int HSC   = 5;
  localparam int ROWS  = 8;
  localparam int SCAN  = 2;
  localparam int VL    = 20;
  localparam int VSS   = 17;
  localparam int VSL   = 2;
  localparam int STR   = 64;
  localparam int TOP   = 7;
  localparam int VD_LO = 1300;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        vdusel_n = 1'b1;
  logic [9:0]  vram_addr;
  logic [7:0]  vram_data = '0;
  logic [10:0] font_addr;
  logic [7:0]  font_data = '0;
  logic        vid_data;
  logic        vid_sync;
  logic        hsync;
  logic        vsync;
  logic        active;

  logic [7:0] vram [1024];
  logic [7:0] font [2048];

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          pos;
    bit          is_font;
    logic [10:0] exp;
    string       name;
  } vec_t;

  vec_t tab [8];

  logic [4:0] sb [$];

  int line_per, hs_len, act_len, vs_len, frame_len;
  int last_hs_rise, act_rise, last_vs_rise;
  logic prev_hs, prev_act, prev_vs;

  nas_vid_gen #(
    .CLK_DIV(CD), .H_CHARS(HC), .COLS(COLS),
    .H_SYNC_START(HSS), .H_SYNC_CHARS(HSC),
    .ROWS(ROWS), .SCAN(SCAN), .V_LINES(VL),
    .V_SYNC_START(VSS), .V_SYNC_LINES(VSL),
    .H_STRIDE(STR), .TOP_ROW(TOP)
  ) dut (
    .clk(clk), .rst(rst), .vdusel_n(vdusel_n),
    .vram_addr(vram_addr), .vram_data(vram_data),
    .font_addr(font_addr), .font_data(font_data),
    .vid_data(vid_data), .vid_sync(vid_sync),
    .hsync(hsync), .vsync(vsync), .active(active)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    vram_data <= vram[vram_addr];
    font_data <= font[font_addr];
  end

  task automatic chk(string name, int idx, logic [31:0] got,
                     logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s #%0d: got %0h expected %0h", name, idx, got, exp);
    end
  endtask

  // expected {vid_data, vid_sync, hsync, vsync, active} after k pixel enables
  function automatic logic [4:0] model(int k, logic vdn);
    int q, pos, ln, sl, dt, mrow, a;
    logic hs, vs, ac, vd;
    logic [7:0] ch, g;
    logic [10:0] fa;
    q = k - 16;
    if (q < 0) return 5'b01000;
    pos = q % (8 * HC * VL);
    ln  = pos / (8 * HC);
    sl  = (pos / 8) % HC;
    dt  = pos % 8;
    hs  = sl >= HSS && sl < HSS + HSC;
    vs  = ln >= VSS && ln < VSS + VSL;
    ac  = sl < COLS && ln < ROWS * SCAN;
    vd  = 1'b0;
    if (ac) begin
      mrow = (ln / SCAN + TOP) % ROWS;
      a    = (mrow * STR + sl) % 1024;
      ch   = vram[a];
      fa   = {ch[6:0], 4'(ln % SCAN)};
      g    = font[fa];
`ifdef NAS_VID_INVERSE_EN
      if (ch[7]) g = ~g;
`endif
      vd = g[7 - dt] & vdn;
    end
    return {vd, ~(hs | vs), hs, vs, ac};
  endfunction

  task automatic check_reset(string tag);
    chk({tag, "_vram_addr"}, 0, 32'(vram_addr), 0);
    chk({tag, "_font_addr"}, 0, 32'(font_addr), 0);
    chk({tag, "_vid_data"}, 0, 32'(vid_data), 0);
    chk({tag, "_vid_sync"}, 0, 32'(vid_sync), 1);
    chk({tag, "_hsync"}, 0, 32'(hsync), 0);
    chk({tag, "_vsync"}, 0, 32'(vsync), 0);
    chk({tag, "_active"}, 0, 32'(active), 0);
  endtask

  task automatic run(int n, bit use_vd);
    logic [4:0] exp, got;
    logic [7:0] dots;
    int e, q;
    e = 0;
`ifdef NAS_VID_INVERSE_EN
    dots = 8'h55;
`else
    dots = 8'hAA;
`endif
    line_per = -1; hs_len = -1; act_len = -1;
    vs_len = -1; frame_len = -1;
    last_hs_rise = -1; act_rise = -1; last_vs_rise = -1;
    prev_hs = 1'b0; prev_act = 1'b0; prev_vs = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      e++;
      vdusel_n = !(use_vd && e >= VD_LO && e < VD_LO + 32);
      sb.push_back(model(e / CD, vdusel_n));
      @(negedge clk);
      got = {vid_data, vid_sync, hsync, vsync, active};
      exp = sb.pop_front();
      chk("raster", e, 32'(got), 32'(exp));
      for (int t = 0; t < 8; t++) begin
        if (e == CD * tab[t].pos + 8) begin
          if (tab[t].is_font) chk(tab[t].name, e, 32'(font_addr), 32'(tab[t].exp));
          else chk(tab[t].name, e, 32'(vram_addr), 32'(tab[t].exp));
        end
      end
      q = e / CD - 16;
      if (q >= 0 && q < 8) chk("first_dots", q, 32'(vid_data), 32'(dots[7 - q]));
      if (hsync && !prev_hs) begin
        if (last_hs_rise >= 0) line_per = e - last_hs_rise;
        last_hs_rise = e;
      end
      if (!hsync && prev_hs) hs_len = e - last_hs_rise;
      if (active && !prev_act) act_rise = e;
      if (!active && prev_act) act_len = e - act_rise;
      if (vsync && !prev_vs) begin
        if (last_vs_rise >= 0) frame_len = e - last_vs_rise;
        last_vs_rise = e;
      end
      if (!vsync && prev_vs) vs_len = e - last_vs_rise;
      prev_hs = hsync; prev_act = active; prev_vs = vsync;
    end
    vdusel_n = 1'b1;
  endtask

  initial begin
    tab[0] = '{0,        1'b0, 11'd448, "addr_l0_s0"};
    tab[1] = '{376,      1'b0, 11'd495, "addr_l0_s47"};
    tab[2] = '{512 + 24, 1'b0, 11'd451, "addr_l1_s3"};
    tab[3] = '{1024,     1'b0, 11'd0,   "addr_l2_s0"};
    tab[4] = '{15 * 512 + 504, 1'b0, 11'd447, "addr_l15_s63"};
    tab[5] = '{8,        1'b1, 11'h410, "font_l0_s0"};
    tab[6] = '{16,       1'b1, 11'h7F0, "font_l0_s1"};
    tab[7] = '{512 + 8,  1'b1, 11'h411, "font_l1_s0"};

    for (int i = 0; i < 1024; i++) vram[i] = 8'($urandom);
    for (int i = 0; i < 2048; i++) font[i] = 8'($urandom);
    vram[448] = 8'hC1;
    vram[449] = 8'h7F;
    for (int i = 463; i < 466; i++) vram[i] = 8'h20;
    font[11'h410] = 8'hAA;
    font[11'h201] = 8'hFF;

    #1 rst = 1'b1;
    #1 check_reset("por");
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    run(2 * VL * HC * 8 * CD + 240, 1'b1);
    chk("line_period", 0, 32'(line_per), 1024);
    chk("hsync_width", 0, 32'(hs_len), 80);
    chk("active_width", 0, 32'(act_len), 768);
    chk("vsync_width", 0, 32'(vs_len), VSL * 1024);
    chk("frame_period", 0, 32'(frame_len), VL * 1024);
    chk("pre_rst_active", 0, 32'(active), 1);

    #2 rst = 1'b1;
    #1 check_reset("midrst");
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    run(3000, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nas_vid_gen.md
NAS_VID_GEN -- requirements
Module: nas_vid_gen

Interface
REQ-001 Parameters SHALL be (name, default, meaning): CLK_DIV, 2, clk cycles per pixel; H_CHARS, 64, character slots per line; COLS, 48, visible columns; H_SYNC_START, 52, hsync start slot; H_SYNC_CHARS, 5, hsync width in slots; ROWS, 16, text rows; SCAN, 16, scanlines per text row (1..16); V_LINES, 312, lines per frame; V_SYNC_START, 280, vsync start line; V_SYNC_LINES, 10, vsync width in lines; H_STRIDE, 64, VRAM bytes per text row; TOP_ROW, 15, memory row shown at top of screen.
REQ-002 clk input 1 system clock (16 MHz); all state on rising edge.
REQ-003 rst input 1 asynchronous active-high reset.
REQ-004 vdusel_n input 1 CPU VRAM access in progress, active low.
REQ-005 vram_addr output 10 VRAM read address.
REQ-006 vram_data input 8 VRAM read data, valid 1 clk after vram_addr.
REQ-007 font_addr output 11 character generator address {char[6:0], scan[3:0]}.
REQ-008 font_data input 8 glyph row, valid 1 clk after font_addr, bit 7 leftmost dot.
REQ-009 vid_data output 1 serial dot output.
REQ-010 vid_sync output 1 composite sync, active low.
REQ-011 hsync, vsync, active outputs 1 each: horizontal sync, vertical sync, display-enable, active high.

Function
REQ-012 Pixel enable SHALL pulse once every CLK_DIV clk; all counters advance only on pixel enable.
REQ-013 Dot counter 0..7, slot counter 0..H_CHARS-1, line counter 0..V_LINES-1; each SHALL wrap to 0 and carry into the next.
REQ-014 Scan = line mod SCAN; text row = line / SCAN; vertical active SHALL be line < ROWS*SCAN.
REQ-015 Memory row SHALL be (text row + TOP_ROW) mod ROWS; vram_addr = memory row*H_STRIDE + slot, truncated to 10 bits.
REQ-016 font_addr SHALL be formed from vram_data[6:0] and current scan, 1 clk after vram_data is valid.
REQ-017 font_data SHALL be loaded into an 8-bit shift register at dot 0 of a slot and shifted MSB-first on each pixel enable.
REQ-018 Latency from vram_addr for slot c to first dot of c on vid_data SHALL be exactly 2 slots (16 pixel enables); hsync, vsync, active SHALL be delayed identically so all align.
REQ-019 active SHALL be high only when (delayed) slot < COLS and vertical active; vid_data SHALL be 0 whenever active is low.
REQ-020 hsync high for slots H_SYNC_START..H_SYNC_START+H_SYNC_CHARS-1; vsync high for lines V_SYNC_START..V_SYNC_START+V_SYNC_LINES-1.
REQ-021 vid_sync SHALL be low when hsync or vsync is high, else high.
REQ-022 vdusel_n low SHALL force vid_data to 0 for the affected dots; counters and sync timing SHALL be unaffected.
REQ-023 Parameter legality: COLS<=H_CHARS, H_SYNC_START+H_SYNC_CHARS<=H_CHARS, ROWS*SCAN<=V_SYNC_START, V_SYNC_START+V_SYNC_LINES<=V_LINES; violation SHALL be a elaboration-time error.

Reset
REQ-024 rst high SHALL immediately clear all counters, pipeline and shift register regardless of clock.
REQ-025 Reset values: vram_addr 0, font_addr 0, vid_data 0, vid_sync 1, hsync 0, vsync 0, active 0.
REQ-026 After rst falls, first pixel enable SHALL occur on the CLK_DIV-th clk edge; frame restarts at line 0 slot 0.

Configuration
REQ-027 Macro NAS_VID_INVERSE_EN defined: vram_data[7]=1 SHALL invert all 8 glyph bits before loading the shift register.
REQ-028 Macro undefined: vram_data[7] SHALL be ignored; no inversion logic present.

Verification
REQ-029 Assert rst mid-line during active video -> outputs take REQ-025 values within the same clk, no edge required.
REQ-030 Defaults, free run -> line period 1024 clk, hsync high 80 clk, active high 768 clk per active line, vsync high 10240 clk, frame 319488 clk.
REQ-031 Defaults, line 0 -> vram_addr 960 at slot 0, 1007 at slot 47; line 16 -> vram_addr 0 at slot 0.
REQ-032 VRAM[960]=0x41, font returns 0xAA for {0x41,0} -> first active dots of line 0 are 1,0,1,0,1,0,1,0, each 2 clk wide.
REQ-033 vdusel_n low for 32 clk mid active line -> vid_data 0 for those clk; hsync edges unchanged.
REQ-034 VRAM[960]=0xC1, font 0xAA -> dots 0x55 with NAS_VID_INVERSE_EN defined, 0xAA without.
